// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate slice.
// Used by mac_accum and acc_sat_add.
package mac_pkg;

    // Accumulator FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Product width from the 4x4 multiplier stage
    localparam int PROD_W = 8;

    // Largest product the multiplier can emit (15 * 15)
    localparam int PROD_MAX = 225;

    // A burst closes on an explicit last flag or when the term budget is used up
    function automatic logic burst_done(
        input logic last,
        input logic cnt_at_max
    );
        return last | cnt_at_max;
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational W-bit adder with carry-out and optional clamp.
// Macro MAC_ACCUM_SATURATE_EN selects clamp-to-all-ones on carry.
module acc_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full;

    // Widen by one bit so the carry is observable, then wrap or clamp
    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[W];
`ifdef MAC_ACCUM_SATURATE_EN
        sum   = carry ? {W{1'b1}} : full[W-1:0];
`else
        sum   = full[W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accum.sv
// Burst accumulator behind the multiplier; valid/ready on both sides.
// Macro MAC_ACCUM_SATURATE_EN makes the accumulator clamp instead of wrap.
module mac_accum
    import mac_pkg::*;
#(
    parameter  int ACC_W     = 16,
    parameter  int MAX_TERMS = 16,
    localparam int CNT_W     = $clog2(MAX_TERMS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              ovf
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             cnt_at_max;
    logic             end_burst;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             carry;

    assign prod_ext   = ACC_W'(prod);
    assign prod_ready = (state_q != HOLD);
    assign accept     = prod_valid & prod_ready;
    assign cnt_at_max = (cnt_q == CNT_W'(MAX_TERMS - 1));
    assign end_burst  = burst_done(prod_last, cnt_at_max);

    acc_sat_add #(
        .W(ACC_W)
    ) u_add (
        .a    (acc_q),
        .b    (prod_ext),
        .sum  (sum),
        .carry(carry)
    );

    // Next-state, accumulate and result-handshake decode
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | carry;
                    if (end_burst) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial burst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign term_cnt  = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum (16-bit and 10-bit accumulators).
// Expected 10-bit overflow result follows MAC_ACCUM_SATURATE_EN.
module tb_mac_accum;

    logic        clk;
    logic        rst_n;
    logic        prod_valid;
    logic [7:0]  prod;
    logic        prod_last;
    logic        out_ready;

    logic        prod_ready;
    logic        out_valid;
    logic [15:0] acc_out;
    logic [4:0]  term_cnt;
    logic        ovf;

    logic        prod_ready10;
    logic        out_valid10;
    logic [9:0]  acc_out10;
    logic [4:0]  term_cnt10;
    logic        ovf10;

`ifdef MAC_ACCUM_SATURATE_EN
    localparam int WRAP10 = 1023;
`else
    localparam int WRAP10 = 101;
`endif

    mac_accum #(.ACC_W(16), .MAX_TERMS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .prod      (prod),
        .prod_last (prod_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .term_cnt  (term_cnt),
        .ovf       (ovf)
    );

    mac_accum #(.ACC_W(10), .MAX_TERMS(16)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready10),
        .prod      (prod),
        .prod_last (prod_last),
        .out_valid (out_valid10),
        .out_ready (out_ready),
        .acc_out   (acc_out10),
        .term_cnt  (term_cnt10),
        .ovf       (ovf10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } res_t;

    typedef struct {
        int n;
        int p[5];
        int gap;
        int acc;
        int cnt;
        int ovf;
        int acc10;
        int ovf10;
    } vec_t;

    res_t sb[$];
    vec_t tbl[5];
    int   n_tests;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int a, input int c, input int o);
        res_t r;
        r.acc = a;
        r.cnt = c;
        r.ovf = o;
        sb.push_back(r);
    endtask

    // Offer one product; returns on the negedge after it was accepted
    task automatic send(input int p, input bit last, input int gap);
        int w;
        prod_valid = 1'b1;
        prod       = 8'(p);
        prod_last  = last;
        w = 0;
        while (prod_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got %0d expected 0", w);
        end
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Compare the presented result with the scoreboard, then hand it off
    task automatic collect();
        res_t e;
        int   w;
        w = 0;
        while (out_valid !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("result_latency", w, 0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("acc_out", acc_out, e.acc);
            chk("term_cnt", term_cnt, e.cnt);
            chk("ovf", ovf, e.ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_clear", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        tbl[0] = '{3, '{225, 225, 10, 0, 0}, 2, 460, 3, 0, 460, 0};
        tbl[1] = '{5, '{225, 225, 225, 225, 225}, 0, 1125, 5, 0, WRAP10, 1};
        tbl[2] = '{1, '{200, 0, 0, 0, 0}, 0, 200, 1, 0, 200, 0};
        tbl[3] = '{4, '{0, 0, 0, 0, 0}, 1, 0, 4, 0, 0, 0};
        tbl[4] = '{4, '{100, 200, 150, 50, 0}, 0, 500, 4, 0, 500, 0};

        // Reset with traffic present
        rst_n      = 1'b0;
        prod_valid = 1'b1;
        prod       = 8'd55;
        prod_last  = 1'b1;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_term_cnt", term_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_prod_ready", prod_ready, 1);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        // Table of bursts, both widths in lockstep
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < tbl[v].n; i++)
                send(tbl[v].p[i], i == tbl[v].n - 1,
                     (i == tbl[v].n - 1) ? 0 : tbl[v].gap);
            push(tbl[v].acc, tbl[v].cnt, tbl[v].ovf);
            chk("w10_out_valid", out_valid10, 1);
            chk("w10_acc_out", acc_out10, tbl[v].acc10);
            chk("w10_term_cnt", term_cnt10, tbl[v].cnt);
            chk("w10_ovf", ovf10, tbl[v].ovf10);
            chk("w10_prod_ready", prod_ready10, 0);
            collect();
        end

        // Backpressure in HOLD with products being offered
        send(225, 0, 1);
        send(225, 0, 1);
        send(10, 1, 0);
        push(460, 3, 0);
        prod_valid = 1'b1;
        prod       = 8'd7;
        prod_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_acc_out", acc_out, 460);
            chk("bp_term_cnt", term_cnt, 3);
            chk("bp_prod_ready", prod_ready, 0);
        end
        collect();
        chk("bp_idle_ready", prod_ready, 1);
        chk("bp_idle_cnt", term_cnt, 0);
        chk("bp_idle_acc", acc_out, 0);
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        push(7, 1, 0);
        collect();

        // Term budget forces end of burst
        for (int i = 0; i < 16; i++) send(1, 0, 0);
        push(16, 16, 0);
        prod_valid = 1'b1;
        prod       = 8'd2;
        prod_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("max_prod_ready", prod_ready, 0);
            chk("max_term_cnt", term_cnt, 16);
            chk("max_acc_out", acc_out, 16);
        end
        collect();
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        push(2, 1, 0);
        collect();

        // Reset in the middle of a burst
        send(50, 0, 0);
        send(60, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_acc", acc_out, 0);
        chk("mid_rst_cnt", term_cnt, 0);
        chk("mid_rst_ready", prod_ready, 1);
        send(5, 1, 0);
        push(5, 1, 0);
        collect();

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
